vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA timing decoder: measures line/frame geometry from the syncs, locks on
// two identical frames and re-emits qualified pixels with active X/Y indices.
module vga_sync_decoder #(
    parameter int CW      = 13,
    parameter int TIMEOUT = 4096
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iVGA_H_SYNC,
    input  logic          iVGA_V_SYNC,
    input  logic          iVGA_BLANK,
    input  logic [7:0]    iRed,
    input  logic [7:0]    iGreen,
    input  logic [7:0]    iBlue,
    output logic [7:0]    oR,
    output logic [7:0]    oG,
    output logic [7:0]    oB,
    output logic          oPixValid,
    output logic [CW-1:0] oX,
    output logic [CW-1:0] oY,
    output logic          oFrameStart,
    output logic [CW-1:0] oLineTotal,
    output logic [CW-1:0] oFrameLines,
    output logic [CW-1:0] oActWidth,
    output logic [CW-1:0] oActHeight,
    output logic          oLocked
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        CHECK,
        LOCKED
    } state_t;

    state_t state;

    logic          hsD1, vsD1, blankD1;
    logic [7:0]    rD1, gD1, bD1;
    logic [CW-1:0] hcnt, xcnt, yIdx;
    logic [CW-1:0] lineCnt, lastLen, maxRun;
    logic [TW-1:0] noHs;
    logic [CW-1:0] snapLT, snapFL, snapW, snapH;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic          hsFall, vsFall, blankRise, blankFall;
    logic [CW-1:0] lineLen, run;
    logic [CW-1:0] linesNow, lastNow, widthNow, heightNow;
    logic          match, timedOut;

    assign hsFall    = hsD1 & ~iVGA_H_SYNC;
    assign vsFall    = vsD1 & ~iVGA_V_SYNC;
    assign blankRise = iVGA_BLANK & ~blankD1;
    assign blankFall = ~iVGA_BLANK & blankD1;

    assign lineLen = satInc(hcnt);
    assign run     = satInc(xcnt);

    // Closing-frame values include any edge seen in this very cycle
    assign linesNow  = hsFall ? satInc(lineCnt) : lineCnt;
    assign lastNow   = hsFall ? lineLen : lastLen;
    assign widthNow  = (blankFall && run > maxRun) ? run : maxRun;
    assign heightNow = blankFall ? satInc(yIdx) : yIdx;

    assign match = (linesNow == snapFL) && (lastNow == snapLT) &&
                   (widthNow == snapW) && (heightNow == snapH);

    assign timedOut = (state != SEARCH) && !hsFall && (noHs >= TO_LAST);

    assign oPixValid = blankD1 & oLocked;
    assign oR = oPixValid ? rD1 : 8'd0;
    assign oG = oPixValid ? gD1 : 8'd0;
    assign oB = oPixValid ? bD1 : 8'd0;
    assign oX = xcnt;
    assign oY = yIdx;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= SEARCH;
            hsD1        <= 1'b1;
            vsD1        <= 1'b1;
            blankD1     <= 1'b0;
            rD1         <= '0;
            gD1         <= '0;
            bD1         <= '0;
            hcnt        <= '0;
            xcnt        <= '0;
            yIdx        <= '0;
            lineCnt     <= '0;
            lastLen     <= '0;
            maxRun      <= '0;
            noHs        <= '0;
            snapLT      <= '0;
            snapFL      <= '0;
            snapW       <= '0;
            snapH       <= '0;
            oLineTotal  <= '0;
            oFrameLines <= '0;
            oActWidth   <= '0;
            oActHeight  <= '0;
            oFrameStart <= 1'b0;
            oLocked     <= 1'b0;
        end else begin
            hsD1        <= iVGA_H_SYNC;
            vsD1        <= iVGA_V_SYNC;
            blankD1     <= iVGA_BLANK;
            rD1         <= iRed;
            gD1         <= iGreen;
            bD1         <= iBlue;
            oFrameStart <= vsFall;

            hcnt <= hsFall ? '0 : satInc(hcnt);
            noHs <= hsFall ? '0 : ((noHs == '1) ? noHs : noHs + 1'b1);

            if (blankRise)
                xcnt <= '0;
            else if (iVGA_BLANK)
                xcnt <= satInc(xcnt);

            // yIdx doubles as the per-frame active-line count
            if (vsFall) begin
                lineCnt <= '0;
                lastLen <= '0;
                maxRun  <= '0;
                yIdx    <= '0;
            end else begin
                lineCnt <= linesNow;
                lastLen <= lastNow;
                maxRun  <= widthNow;
                yIdx    <= heightNow;
            end

            if (timedOut) begin
                state   <= SEARCH;
                oLocked <= 1'b0;
            end else if (vsFall) begin
                unique case (state)
                    SEARCH: begin
                        state <= MEASURE;
                    end
                    MEASURE: begin
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (match) begin
                            state   <= LOCKED;
                            oLocked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            state   <= CHECK;
                            oLocked <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= SEARCH;
                        oLocked <= 1'b0;
                    end
                endcase

                if (state != SEARCH) begin
                    snapLT <= lastNow;
                    snapFL <= linesNow;
                    snapW  <= widthNow;
                    snapH  <= heightNow;
                end

                if ((state == CHECK || state == LOCKED) && match) begin
                    oLineTotal  <= lastNow;
                    oFrameLines <= linesNow;
                    oActWidth   <= widthNow;
                    oActHeight  <= heightNow;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced raster
// (40 clk/line, 6 hsync, 24 active; 16 lines, 2 vsync, 10 active).
module tb_vga_sync_decoder;

    localparam int CW  = 13;
    localparam int TO  = 4096;
    localparam int HT  = 40;
    localparam int HS  = 6;
    localparam int HA0 = 10;
    localparam int HA  = 24;
    localparam int VS  = 2;
    localparam int VA0 = 4;
    localparam int VA  = 10;

    localparam int OP_FRM  = 0;
    localparam int OP_IDLE = 1;
    localparam int OP_RST  = 2;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iVGA_H_SYNC = 1'b1;
    logic          iVGA_V_SYNC = 1'b1;
    logic          iVGA_BLANK = 1'b0;
    logic [7:0]    iRed = '0, iGreen = '0, iBlue = '0;
    logic [7:0]    oR, oG, oB;
    logic          oPixValid, oFrameStart, oLocked;
    logic [CW-1:0] oX, oY, oLineTotal, oFrameLines, oActWidth, oActHeight;

    vga_sync_decoder #(.CW(CW), .TIMEOUT(TO)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iVGA_H_SYNC(iVGA_H_SYNC), .iVGA_V_SYNC(iVGA_V_SYNC),
        .iVGA_BLANK(iVGA_BLANK),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oR(oR), .oG(oG), .oB(oB),
        .oPixValid(oPixValid), .oX(oX), .oY(oY),
        .oFrameStart(oFrameStart),
        .oLineTotal(oLineTotal), .oFrameLines(oFrameLines),
        .oActWidth(oActWidth), .oActHeight(oActHeight),
        .oLocked(oLocked)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int op;
        int vt;
        int vsOff;
        int arg;
        bit chkPix;
        bit expLk;
        int lt;
        int fl;
        int w;
        int h;
    } vec_t;

    vec_t vecs[18];
    int   nTests = 0;
    int   nFail  = 0;
    int   fsCnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic v, input logic bl,
                        input logic rs, input logic [7:0] rr,
                        input logic [7:0] gg, input logic [7:0] bb);
        iVGA_H_SYNC = h;
        iVGA_V_SYNC = v;
        iVGA_BLANK  = bl;
        iRST        = rs;
        iRed        = rr;
        iGreen      = gg;
        iBlue       = bb;
        @(posedge iCLK);
        #1;
        if (oFrameStart) fsCnt++;
    endtask

    task automatic chkZero(input string tag);
        chk({tag, " oR"}, oR, 0);
        chk({tag, " oG"}, oG, 0);
        chk({tag, " oB"}, oB, 0);
        chk({tag, " oPixValid"}, oPixValid, 0);
        chk({tag, " oX"}, oX, 0);
        chk({tag, " oY"}, oY, 0);
        chk({tag, " oFrameStart"}, oFrameStart, 0);
        chk({tag, " oLineTotal"}, oLineTotal, 0);
        chk({tag, " oFrameLines"}, oFrameLines, 0);
        chk({tag, " oActWidth"}, oActWidth, 0);
        chk({tag, " oActHeight"}, oActHeight, 0);
        chk({tag, " oLocked"}, oLocked, 0);
    endtask

    task automatic runFrame(input int id, input int vt, input int vsOff,
                            input int rstLine, input bit chkPix,
                            input bit expLk);
        logic       h, v, bl, rs;
        logic [7:0] rr, gg, bb;
        string      tag;
        fsCnt = 0;
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < HT; c++) begin
                h  = (c >= HS);
                v  = !((l == 0 && c >= vsOff) || (l > 0 && l < VS) ||
                       (l == VS && c < vsOff));
                bl = (l >= VA0 && l < VA0 + VA && c >= HA0 && c < HA0 + HA);
                rr = (l == VA0 && c == HA0) ? 8'hA5 : 8'(c * 7 + l * 3);
                gg = 8'(l * 16 + c);
                bb = rr ^ 8'h3C;
                rs = (l == rstLine && c == 0);
                step(h, v, bl, rs, rr, gg, bb);
                tag = $sformatf("row%0d l%0d c%0d", id, l, c);
                if (rs) chkZero({tag, " reset"});
                if (l == 0 && c == vsOff) begin
                    chk({tag, " frameStart"}, oFrameStart, 1);
                    chk({tag, " locked"}, oLocked, expLk);
                end
                if (chkPix) begin
                    if (bl && expLk) begin
                        chk({tag, " pixValid"}, oPixValid, 1);
                        chk({tag, " x"}, oX, c - HA0);
                        chk({tag, " y"}, oY, l - VA0);
                        chk({tag, " r"}, oR, rr);
                        chk({tag, " g"}, oG, gg);
                        chk({tag, " b"}, oB, bb);
                    end else begin
                        chk({tag, " pixValid"}, oPixValid, 0);
                        chk({tag, " rgbBlank"}, {oR, oG, oB}, 0);
                    end
                end
            end
        end
        chk($sformatf("row%0d frameStartPulses", id), fsCnt, 1);
    endtask

    task automatic runIdle(input int id, input int n, input bit expLk);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
        chk($sformatf("row%0d idle locked", id), oLocked, expLk);
        chk($sformatf("row%0d idle pixValid", id), oPixValid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_FRM,  16, 3, 0,       1'b1, 1'b0, 0,  0,  0,  0};
        vecs[1]  = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 0,  0,  0,  0};
        vecs[2]  = '{OP_FRM,  16, 3, 0,       1'b1, 1'b1, 40, 16, 24, 10};
        vecs[3]  = '{OP_FRM,  15, 3, 0,       1'b0, 1'b1, 40, 16, 24, 10};
        vecs[4]  = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 40, 16, 24, 10};
        vecs[5]  = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 40, 16, 24, 10};
        vecs[6]  = '{OP_FRM,  16, 3, 0,       1'b0, 1'b1, 40, 16, 24, 10};
        vecs[7]  = '{OP_FRM,  16, 0, 0,       1'b1, 1'b1, 40, 16, 24, 10};
        vecs[8]  = '{OP_FRM,  16, 3, 0,       1'b0, 1'b1, 40, 16, 24, 10};
        vecs[9]  = '{OP_IDLE, 0,  0, TO - HT, 1'b0, 1'b1, 40, 16, 24, 10};
        vecs[10] = '{OP_IDLE, 0,  0, 1,       1'b0, 1'b0, 40, 16, 24, 10};
        vecs[11] = '{OP_FRM,  16, 3, 0,       1'b1, 1'b0, 40, 16, 24, 10};
        vecs[12] = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 40, 16, 24, 10};
        vecs[13] = '{OP_FRM,  16, 3, 0,       1'b0, 1'b1, 40, 16, 24, 10};
        vecs[14] = '{OP_RST,  16, 3, 8,       1'b0, 1'b1, 0,  0,  0,  0};
        vecs[15] = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 0,  0,  0,  0};
        vecs[16] = '{OP_FRM,  16, 3, 0,       1'b0, 1'b0, 0,  0,  0,  0};
        vecs[17] = '{OP_FRM,  16, 3, 0,       1'b1, 1'b1, 40, 16, 24, 10};

        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
        chkZero("inReset");
        step(1, 1, 0, 0, 0, 0, 0);
        chkZero("postReset");

        for (int i = 0; i < 18; i++) begin
            case (vecs[i].op)
                OP_IDLE: runIdle(i, vecs[i].arg, vecs[i].expLk);
                OP_RST:  runFrame(i, vecs[i].vt, vecs[i].vsOff, vecs[i].arg,
                                  vecs[i].chkPix, vecs[i].expLk);
                default: runFrame(i, vecs[i].vt, vecs[i].vsOff, -1,
                                  vecs[i].chkPix, vecs[i].expLk);
            endcase
            chk($sformatf("row%0d lineTotal", i), oLineTotal, vecs[i].lt);
            chk($sformatf("row%0d frameLines", i), oFrameLines, vecs[i].fl);
            chk($sformatf("row%0d actWidth", i), oActWidth, vecs[i].w);
            chk($sformatf("row%0d actHeight", i), oActHeight, vecs[i].h);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
